// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the CPU/DMA data-memory bus arbiter.
// Holds the state encoding and the default timing constants.
package dma_bus_arbiter_pkg;

    // Arbiter states; the encoding is visible on arb_state for debug.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    // One DMA transfer is a 3x4-word burst taking 12 bus cycles.
    localparam int DMA_XFER_LEN   = 12;
    // Watchdog limit gives a normal burst some slack before it is cut off.
    localparam int DEF_MAX_GRANT  = DMA_XFER_LEN + 4;
    localparam int DEF_TURNAROUND = 1;
    localparam int DEF_CNT_W      = 5;
    localparam int TA_W           = 3;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bus-ownership handshake between CPU, DMA engine and the arbiter.
// slave: the arbiter side. master: the CPU/DMA (or bench) side.
interface dma_bus_arbiter_if;
    logic       BR;
    logic       cpu_req;
    logic       cpu_bus_busy;
    logic       BG;
    logic       cpu_stall;
    logic [1:0] arb_state;
    logic       grant_err;

    modport slave (
        input  BR, cpu_req, cpu_bus_busy,
        output BG, cpu_stall, arb_state, grant_err
    );

    modport master (
        output BR, cpu_req, cpu_bus_busy,
        input  BG, cpu_stall, arb_state, grant_err
    );
endinterface

// File: rtl/dma_bus_arbiter_turnaround_cnt.sv
// Loadable down-counter timing the RELEASE turnaround gap.
// done is high while the count is zero.
module arb_turnaround_cnt #(
    parameter int W = 3
) (
    input  logic         CLK,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);
    logic [W-1:0] cnt_reg;

    // Load on entry to RELEASE, then count down to zero while enabled.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);
endmodule

// File: rtl/dma_bus_arbiter.sv
// CPU/DMA shared data-memory bus arbiter.
// Drains in-flight CPU accesses, grants the bus to the DMA engine with a
// registered BG, stalls new CPU accesses, and inserts a turnaround gap on
// release. Optional grant watchdog: define ARB_WATCHDOG_EN.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter int TURNAROUND = DEF_TURNAROUND,
    parameter int MAX_GRANT  = DEF_MAX_GRANT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              reset_n,
    dma_bus_arbiter_if.slave  bus
);
    // Reject parameter sets the counters cannot represent.
    if ((TURNAROUND < 1) || (TURNAROUND > 7) || ((1 << CNT_W) <= MAX_GRANT)) begin : g_bad_cfg
        $error("dma_bus_arbiter: illegal TURNAROUND/MAX_GRANT/CNT_W combination");
    end

    arb_state_t state_reg;
    logic       bg_reg;
    logic       grant_exit;
    logic       wd_trip;
    logic       ta_done;

    // A grant ends when the DMA drops BR or the watchdog cuts it off.
    assign grant_exit = (state_reg == ST_GRANT) && (!bus.BR || wd_trip);

`ifdef ARB_WATCHDOG_EN
    logic [CNT_W-1:0] grant_cnt_reg;
    logic             grant_err_reg;

    // Trip on the edge where the grant length reaches MAX_GRANT cycles.
    assign wd_trip = (state_reg == ST_GRANT) &&
                     (grant_cnt_reg == CNT_W'(MAX_GRANT - 1));

    // Grant-length counter (saturating) and sticky watchdog error flag.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            grant_cnt_reg <= '0;
            grant_err_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_GRANT) && !grant_exit) begin
                if (grant_cnt_reg != '1) begin
                    grant_cnt_reg <= grant_cnt_reg + 1'b1;
                end
            end else begin
                grant_cnt_reg <= '0;
            end
            if (wd_trip) begin
                grant_err_reg <= 1'b1;
            end
        end
    end

    assign bus.grant_err = grant_err_reg;
`else
    assign wd_trip       = 1'b0;
    assign bus.grant_err = 1'b0;
`endif

    arb_turnaround_cnt #(.W(TA_W)) u_ta_cnt (
        .CLK      (CLK),
        .reset_n  (reset_n),
        .load     (grant_exit),
        .load_val (TA_W'(TURNAROUND - 1)),
        .en       (state_reg == ST_RELEASE),
        .done     (ta_done)
    );

    // Bus-ownership FSM with registered grant output.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            bg_reg    <= 1'b0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.BR) begin
                        if (bus.cpu_bus_busy) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            state_reg <= ST_GRANT;
                            bg_reg    <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!bus.BR) begin
                        state_reg <= ST_IDLE;
                    end else if (!bus.cpu_bus_busy) begin
                        state_reg <= ST_GRANT;
                        bg_reg    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (grant_exit) begin
                        state_reg <= ST_RELEASE;
                        bg_reg    <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    if (ta_done) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    bg_reg    <= 1'b0;
                end
            endcase
        end
    end

    // CPU stall: let an in-flight access finish in DRAIN, block new ones
    // whenever the DMA owns the bus or the lines are turning around.
    always_comb begin
        bus.cpu_stall = 1'b0;
        unique case (state_reg)
            ST_IDLE:    bus.cpu_stall = 1'b0;
            ST_DRAIN:   bus.cpu_stall = bus.cpu_req & ~bus.cpu_bus_busy;
            ST_GRANT:   bus.cpu_stall = bus.cpu_req;
            ST_RELEASE: bus.cpu_stall = bus.cpu_req;
            default:    bus.cpu_stall = 1'b0;
        endcase
    end

    assign bus.BG        = bg_reg;
    assign bus.arb_state = state_reg;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed vector table,
// hand-written reset/watchdog sequences and randomized traffic checked
// against a behavioural ownership model.
module tb_dma_bus_arbiter;
    localparam int TURNAROUND = 1;
    localparam int MAX_GRANT  = 16;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic CLK     = 1'b0;
    logic reset_n = 1'b0;

    dma_bus_arbiter_if bus();

    dma_bus_arbiter #(
        .TURNAROUND (TURNAROUND),
        .MAX_GRANT  (MAX_GRANT),
        .CNT_W      (5)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    logic last_bg;

    // Behavioural model: who owns the bus, how long the DMA has held it,
    // and how many gap cycles remain before the CPU gets it back.
    // phase: 0 CPU owns, 1 waiting for CPU access to finish, 2 DMA owns, 3 gap
    int m_phase, m_gap, m_glen;
    bit m_err;

    function automatic void model_reset();
        m_phase = 0; m_gap = 0; m_glen = 0; m_err = 1'b0;
    endfunction

    function automatic void model_step(input bit br, input bit busy);
        case (m_phase)
            0: if (br) begin m_phase = busy ? 1 : 2; m_glen = 0; end
            1: begin
                if (!br) m_phase = 0;
                else if (!busy) begin m_phase = 2; m_glen = 0; end
            end
            2: begin
                m_glen++;
                if (WD && m_glen >= MAX_GRANT) m_err = 1'b1;
                if (!br || (WD && m_glen >= MAX_GRANT)) begin
                    m_phase = 3; m_gap = TURNAROUND; m_glen = 0;
                end
            end
            default: begin
                m_gap--;
                if (m_gap == 0) m_phase = 0;
            end
        endcase
    endfunction

    function automatic logic [4:0] model_out(input bit req, input bit busy);
        logic bg, stall;
        bg    = (m_phase == 2);
        stall = (m_phase >= 2) ? req : ((m_phase == 1) ? (req && !busy) : 1'b0);
        return {bg, stall, 2'(m_phase), m_err};
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.BG, bus.cpu_stall, bus.arb_state, bus.grant_err};
        last_bg = bus.BG;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: BG/stall/state/err got %b/%b/%0d/%b want %b/%b/%0d/%b",
                     name, act[4], act[3], act[2:1], act[0], exp[4], exp[3], exp[2:1], exp[0]);
        end
    endtask

    // One clock: drive inputs, check mid-cycle, clock, advance model.
    task automatic run_cycle(input bit br, input bit req, input bit busy, input string name,
                             input bit use_exp, input logic [4:0] exp);
        bus.BR = br; bus.cpu_req = req; bus.cpu_bus_busy = busy;
        @(negedge CLK);
        check(name, use_exp ? exp : model_out(req, busy));
        @(posedge CLK);
        model_step(br, busy);
        #1;
    endtask

    task automatic do_reset();
        bus.BR = 1'b0; bus.cpu_req = 1'b0; bus.cpu_bus_busy = 1'b0;
        reset_n = 1'b0;
        @(negedge CLK);
        check("reset_state", 5'b0);
        reset_n = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit         br, req, busy;
        logic [4:0] exp;   // {BG, cpu_stall, arb_state[1:0], grant_err}
    } vec_t;

    vec_t tbl[17];

    initial begin
        int first_run;
        bit rising_seen, run_done;
        bit br_r;

        // {br, req, busy} during the cycle -> outputs in that cycle
        tbl[0]  = '{0, 0, 1, 5'b0_0_00_0};
        tbl[1]  = '{1, 0, 1, 5'b0_0_00_0};   // BR with CPU busy -> DRAIN
        tbl[2]  = '{1, 1, 1, 5'b0_0_01_0};   // in-flight access not stalled
        tbl[3]  = '{1, 1, 1, 5'b0_0_01_0};
        tbl[4]  = '{1, 1, 0, 5'b0_1_01_0};   // busy gone: new access stalled
        tbl[5]  = '{1, 1, 0, 5'b1_1_10_0};   // GRANT
        tbl[6]  = '{1, 0, 0, 5'b1_0_10_0};
        tbl[7]  = '{0, 1, 0, 5'b1_1_10_0};   // BR drops
        tbl[8]  = '{1, 1, 0, 5'b0_1_11_0};   // RELEASE, BR reassert ignored
        tbl[9]  = '{1, 1, 0, 5'b0_0_00_0};   // IDLE one cycle, no stall
        tbl[10] = '{1, 0, 0, 5'b1_0_10_0};   // regrant
        tbl[11] = '{0, 0, 0, 5'b1_0_10_0};
        tbl[12] = '{0, 0, 0, 5'b0_0_11_0};
        tbl[13] = '{0, 0, 1, 5'b0_0_00_0};
        tbl[14] = '{1, 0, 1, 5'b0_0_00_0};   // -> DRAIN
        tbl[15] = '{0, 1, 1, 5'b0_0_01_0};   // BR withdrawn in DRAIN
        tbl[16] = '{0, 1, 0, 5'b0_0_00_0};   // back in IDLE, BG never rose

        bus.BR = 1'b0; bus.cpu_req = 1'b0; bus.cpu_bus_busy = 1'b0;
        #1;
        do_reset();

        foreach (tbl[i])
            run_cycle(tbl[i].br, tbl[i].req, tbl[i].busy, $sformatf("table_%0d", i), 1'b1, tbl[i].exp);

        // Reset in the middle of a grant: BG must drop before the next edge.
        run_cycle(1, 0, 0, "pre_reset_idle", 1'b1, 5'b0_0_00_0);
        run_cycle(1, 1, 0, "pre_reset_grant", 1'b1, 5'b1_1_10_0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_mid_grant", 5'b0);
        bus.BR = 1'b0; bus.cpu_req = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;

        // BR held for 40 cycles: watchdog bounds the grant when enabled.
        first_run = 0; rising_seen = 1'b0; run_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            run_cycle(1, 1, 0, $sformatf("hold_br_%0d", c), 1'b0, 5'b0);
            if (last_bg && !run_done) begin rising_seen = 1'b1; first_run++; end
            else if (!last_bg && rising_seen) run_done = 1'b1;
        end
        n_vec++;
        if (first_run != (WD ? MAX_GRANT : 39)) begin
            n_bad++;
            $display("FAIL first_grant_len: got %0d want %0d", first_run, WD ? MAX_GRANT : 39);
        end
        n_vec++;
        if (bus.grant_err !== WD) begin
            n_bad++;
            $display("FAIL grant_err_after_hold: got %b want %b", bus.grant_err, WD);
        end
        for (int c = 0; c < 4; c++)
            run_cycle(0, 0, 0, $sformatf("post_hold_%0d", c), 1'b0, 5'b0);

        do_reset();

        // Randomized traffic; CPU never claims busy while the DMA owns the bus.
        br_r = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit req, busy;
            if ($urandom_range(0, 5) == 0) br_r = ~br_r;
            req  = 1'($urandom_range(0, 1));
            busy = (m_phase == 2) ? 1'b0 : ($urandom_range(0, 2) == 0);
            run_cycle(br_r, req, busy, $sformatf("rand_%0d", c), 1'b0, 5'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
